door_led_seq: RTL and testbench
===============================

Name: door_led_seq

Overview:
- Parametrised successor to the elevator door LED animation.
- Drives an LED_W-wide bar that models a two-leaf door. Lit means closed. LEDs extinguish from the centre outward on opening and relight from the edges inward on closing.
- Adds a configurable open-hold time, re-open on button press during closing, and hold extension on press while open.
- Replaces the internal clock divider with a synchronous clock-enable step timer. One clock domain; sits between the call-button debouncer and the board LEDs/floor controller.

Parameters:
- LED_W, 10, number of LEDs; even, >=2; HALF = LED_W/2.
- STEP_CYCLES, 50_000, clk cycles per animation step; >=1.
- HOLD_STEPS, 4, steps the door stays fully open; >=1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- boton  input  1  door/call request, level, already debounced and synchronised
- led  output  LED_W  door image; 1 = leaf segment present (LED lit)
- person_in  output  1  one-cycle pulse when a door cycle completes (closed again)
- busy  output  1  high whenever state != IDLE
- door_open  output  1  high in OPEN_HOLD

Behaviour:
- Reset (rst high at posedge) takes effect next cycle from any state, including mid-animation:
  - state=IDLE, lvl=0, tick_cnt=0, hold_cnt=0.
  - led=all ones, person_in=0, busy=0, door_open=0.
- lvl (0..HALF, width clog2(HALF+1)) is the count of cleared LEDs on each side of centre.
  - led[i]=0 iff HALF-lvl <= i < HALF+lvl; otherwise 1.
  - led is registered or derived purely from lvl; either way it is valid in the same cycle as lvl.
- tick is the step timer. tick_cnt counts 0..STEP_CYCLES-1 and is held at 0 in IDLE. tick=1 when tick_cnt==STEP_CYCLES-1, then tick_cnt wraps to 0. For STEP_CYCLES=1, tick is high every cycle outside IDLE.
- States: IDLE, OPENING, OPEN_HOLD, CLOSING.
- IDLE:
  - boton=1 -> OPENING next cycle, with lvl=0 and tick_cnt=0.
  - boton=0 -> stay.
- OPENING:
  - On tick, lvl+1.
  - When that increment makes lvl==HALF -> OPEN_HOLD with hold_cnt=0.
  - boton is ignored.
- OPEN_HOLD:
  - On tick, hold_cnt+1. A tick with hold_cnt==HOLD_STEPS-1 -> CLOSING.
  - boton=1 clears hold_cnt and tick_cnt, extending the hold; this has priority over tick.
- CLOSING:
  - On tick, lvl-1. When that decrement makes lvl==0 -> IDLE and person_in=1 for exactly the first IDLE cycle.
  - boton=1 -> OPENING with lvl kept and tick_cnt=0 (re-open from current position). Boton wins over a simultaneous tick; no decrement occurs in that cycle, and person_in is not pulsed.
- Re-open never emits person_in. Only a completed CLOSING -> IDLE transition does.
- A boton held high through completion restarts a new cycle one cycle after returning to IDLE.
- Nominal latency from the boton-sampling edge to the person_in edge is 1 + (2*HALF + HOLD_STEPS)*STEP_CYCLES cycles.
- No latch inference; every output is assigned in every state.

Decomposition:
- Shared include door_pkg.vh: state localparams (IDLE=0, OPENING=1, OPEN_HOLD=2, CLOSING=3), STATE_W=2, and a clog2 function.
- One sub-module, step_tick (parameter STEP_CYCLES):
  - Ports clk, rst, clr, en, tick.
  - Synchronous counter that replaces the old clock_divider.
- FSM, lvl/hold counters and the LED decode stay in door_led_seq.

Test Plan:
- Defaults for scenarios 1–3, 5 and 6: LED_W=10, STEP_CYCLES=4, HOLD_STEPS=2.
1. Reset then boton pulse at cycle 0 -> led progression:
   - 1111111111, 1111001111, 1110000111, 1100000011, 1000000001, 0000000000; each new step appears 4 cycles after the previous one.
   - door_open from cycle 21 to 28; reverse sequence follows.
   - person_in single pulse at cycle 49; busy low afterward.
2. boton pulse during CLOSING with lvl=3 (led 1100000011) -> state OPENING, led unchanged; next step (4 cycles later) gives lvl=4 (1000000001); no person_in pulse for the aborted close.
3. boton held 1 for several cycles in OPEN_HOLD -> led stays 0000000000 while held; CLOSING begins 8 cycles after release.
4. boton and tick coincident in CLOSING (STEP_CYCLES=1) -> lvl not decremented that cycle, state OPENING; person_in never asserts while boton is held.
5. rst asserted mid-OPENING at lvl=2 -> next cycle led=1111111111, busy=0, person_in=0; boton=0 afterward keeps IDLE indefinitely.
6. Parameter sweep LED_W=2,16 and HOLD_STEPS=1 -> the latency formula holds exactly (2-LED case: 1+(2+1)*4=13 cycles); led never shows an asymmetric pattern.

Source files
------------

// File: rtl/door_led_seq_pkg.sv
// Shared types and helpers for the door LED sequencer: state encoding and a
// constant-evaluable ceiling log2 used to size counters from parameters.
package door_led_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    OPENING   = 2'd1,
    OPEN_HOLD = 2'd2,
    CLOSING   = 2'd3
  } door_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) < value) begin
        result = r + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/door_led_seq_step_tick.sv
// Animation step timer: a clock-enable pulse every STEP_CYCLES cycles while
// enabled; the count is held at zero while disabled or cleared.
module step_tick
  import door_led_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (clog2(STEP_CYCLES) < 1) ? 1 : clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] tick_cnt_reg;

  assign tick = en && (tick_cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || !en || (tick_cnt_reg == LAST)) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/door_led_seq.sv
// Two-leaf door animation on an LED bar: LEDs go dark from the centre outward
// while opening, hold open, then relight from the edges inward while closing.
module door_led_seq
  import door_led_seq_pkg::*;
#(
  parameter int LED_W       = 10,
  parameter int STEP_CYCLES = 50_000,
  parameter int HOLD_STEPS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boton,
  output logic [LED_W-1:0] led,
  output logic             person_in,
  output logic             busy,
  output logic             door_open
);

  localparam int HALF   = LED_W / 2;
  localparam int LVL_W  = clog2(HALF + 1);
  localparam int HOLD_W = (clog2(HOLD_STEPS) < 1) ? 1 : clog2(HOLD_STEPS);

  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(HALF);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  door_state_t       state_reg, state_next;
  logic [LVL_W-1:0]  lvl_reg, lvl_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              person_in_reg, person_in_next;
  logic              tick;
  logic              tick_clr;

  step_tick #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .en  (state_reg != IDLE),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      lvl_reg       <= '0;
      hold_cnt_reg  <= '0;
      person_in_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lvl_reg       <= lvl_next;
      hold_cnt_reg  <= hold_cnt_next;
      person_in_reg <= person_in_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lvl_next       = lvl_reg;
    hold_cnt_next  = hold_cnt_reg;
    person_in_next = 1'b0;
    tick_clr       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (boton) begin
          state_next = OPENING;
          lvl_next   = '0;
        end
      end
      OPENING: begin
        // A re-open from the very start of CLOSING arrives here already at
        // HALF, so saturate rather than step past the fully open level.
        if (tick) begin
          if (int'(lvl_reg) + 1 >= HALF) begin
            lvl_next      = LVL_FULL;
            state_next    = OPEN_HOLD;
            hold_cnt_next = '0;
          end else begin
            lvl_next = lvl_reg + LVL_ONE;
          end
        end
      end
      OPEN_HOLD: begin
        if (boton) begin
          hold_cnt_next = '0;
          tick_clr      = 1'b1;
        end else if (tick) begin
          if (hold_cnt_reg == HOLD_LAST) begin
            state_next    = CLOSING;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end
      end
      CLOSING: begin
        if (boton) begin
          state_next = OPENING;
          tick_clr   = 1'b1;
        end else if (tick) begin
          if (lvl_reg <= LVL_ONE) begin
            lvl_next       = '0;
            state_next     = IDLE;
            person_in_next = 1'b1;
          end else begin
            lvl_next = lvl_reg - LVL_ONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        lvl_next   = '0;
      end
    endcase
  end

  // LED gi goes dark once lvl reaches its distance from the centre gap.
  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_led
      localparam int DIST = (gi < HALF) ? (HALF - gi) : (gi - HALF + 1);
      assign led[gi] = (lvl_reg < LVL_W'(DIST));
    end
  endgenerate

  assign person_in = person_in_reg;
  assign busy      = (state_reg != IDLE);
  assign door_open = (state_reg == OPEN_HOLD);

endmodule

// File: tb/tb_door_led_seq.sv
// Directed bench for door_led_seq: four instances cover the default timing,
// single-cycle steps and the 2- and 16-LED latency cases.
module tb_door_led_seq;

  logic clk;
  logic rst_a, boton_a, person_in_a, busy_a, door_open_a;
  logic rst_b, boton_b, person_in_b, busy_b, door_open_b;
  logic rst_c, boton_c, person_in_c, busy_c, door_open_c;
  logic rst_d, boton_d, person_in_d, busy_d, door_open_d;
  logic [9:0]  led_a, led_b;
  logic [1:0]  led_c;
  logic [15:0] led_d;

  int checks = 0;
  int errors = 0;

  door_led_seq #(.LED_W(10), .STEP_CYCLES(4), .HOLD_STEPS(2)) dut_a (
    .clk(clk), .rst(rst_a), .boton(boton_a), .led(led_a),
    .person_in(person_in_a), .busy(busy_a), .door_open(door_open_a));

  door_led_seq #(.LED_W(10), .STEP_CYCLES(1), .HOLD_STEPS(2)) dut_b (
    .clk(clk), .rst(rst_b), .boton(boton_b), .led(led_b),
    .person_in(person_in_b), .busy(busy_b), .door_open(door_open_b));

  door_led_seq #(.LED_W(2), .STEP_CYCLES(4), .HOLD_STEPS(1)) dut_c (
    .clk(clk), .rst(rst_c), .boton(boton_c), .led(led_c),
    .person_in(person_in_c), .busy(busy_c), .door_open(door_open_c));

  door_led_seq #(.LED_W(16), .STEP_CYCLES(4), .HOLD_STEPS(1)) dut_d (
    .clk(clk), .rst(rst_d), .boton(boton_d), .led(led_d),
    .person_in(person_in_d), .busy(busy_d), .door_open(door_open_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 with dut_a idle and out of reset.
  task automatic reset_a();
    rst_a = 1'b1;
    boton_a = 1'b0;
    step();
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    boton_a = 1'b0; boton_b = 1'b0; boton_c = 1'b0; boton_d = 1'b0;
    step();
    step();
    obs = {led_a, door_open_a, busy_a, person_in_a};
    checks++;
    if (obs !== {10'b1111111111, 3'b000}) begin
      errors++;
      $display("FAIL reset_a: got %b expected %b", obs, {10'b1111111111, 3'b000});
    end
    checks++;
    if ({led_b, door_open_b, busy_b, person_in_b} !== {10'b1111111111, 3'b000}) begin
      errors++;
      $display("FAIL reset_b: got %b expected %b", {led_b, door_open_b, busy_b, person_in_b}, {10'b1111111111, 3'b000});
    end
    checks++;
    if ({led_c, door_open_c, busy_c, person_in_c} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_c: got %b expected 11000", {led_c, door_open_c, busy_c, person_in_c});
    end
    checks++;
    if ({led_d, door_open_d, busy_d, person_in_d} !== {16'hFFFF, 3'b000}) begin
      errors++;
      $display("FAIL reset_d: got %b expected %b", {led_d, door_open_d, busy_d, person_in_d}, {16'hFFFF, 3'b000});
    end
    // Reset must dominate a simultaneous request.
    boton_a = 1'b1;
    step();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_boton: busy got %b expected 0", busy_a);
    end
    boton_a = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    step();
  endtask

  task automatic test_open_close();
    int tc [17] = '{1, 4, 5, 9, 13, 17, 20, 21, 28, 29, 33, 37, 41, 45, 48, 49, 50};
    logic [12:0] te [17] = '{
      {10'b1111111111, 3'b010}, {10'b1111111111, 3'b010}, {10'b1111001111, 3'b010},
      {10'b1110000111, 3'b010}, {10'b1100000011, 3'b010}, {10'b1000000001, 3'b010},
      {10'b1000000001, 3'b010}, {10'b0000000000, 3'b110}, {10'b0000000000, 3'b110},
      {10'b0000000000, 3'b010}, {10'b1000000001, 3'b010}, {10'b1100000011, 3'b010},
      {10'b1110000111, 3'b010}, {10'b1111001111, 3'b010}, {10'b1111001111, 3'b010},
      {10'b1111111111, 3'b001}, {10'b1111111111, 3'b000}};
    int idx;
    int pulses;
    logic [12:0] obs;
    reset_a();
    boton_a = 1'b1;
    idx = 0;
    pulses = 0;
    for (int cyc = 1; cyc <= 52; cyc++) begin
      step();
      boton_a = 1'b0;
      obs = {led_a, door_open_a, busy_a, person_in_a};
      if (person_in_a === 1'b1) pulses++;
      if (idx < 17 && tc[idx] == cyc) begin
        checks++;
        if (obs !== te[idx]) begin
          errors++;
          $display("FAIL open_close@%0d: got %b expected %b", cyc, obs, te[idx]);
        end
        idx++;
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL open_close_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_reopen();
    int pulses;
    int first_pulse;
    reset_a();
    boton_a = 1'b1;
    for (int cyc = 1; cyc <= 38; cyc++) begin
      step();
      boton_a = 1'b0;
    end
    boton_a = 1'b1;
    step();
    boton_a = 1'b0;
    checks++;
    if ({led_a, door_open_a, busy_a} !== {10'b1100000011, 2'b01}) begin
      errors++;
      $display("FAIL reopen@39: got %b expected %b", {led_a, door_open_a, busy_a}, {10'b1100000011, 2'b01});
    end
    pulses = 0;
    first_pulse = 0;
    for (int cyc = 40; cyc <= 80; cyc++) begin
      step();
      if (person_in_a === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = cyc;
      end
      if (cyc == 42) begin
        checks++;
        if (led_a !== 10'b1100000011) begin
          errors++;
          $display("FAIL reopen@42: got %b expected 1100000011", led_a);
        end
      end
      if (cyc == 43) begin
        checks++;
        if (led_a !== 10'b1000000001) begin
          errors++;
          $display("FAIL reopen@43: got %b expected 1000000001", led_a);
        end
      end
      if (cyc == 47) begin
        checks++;
        if ({led_a, door_open_a} !== 11'b00000000001) begin
          errors++;
          $display("FAIL reopen@47: got %b expected 00000000001", {led_a, door_open_a});
        end
      end
    end
    checks++;
    if (pulses !== 1 || first_pulse !== 75) begin
      errors++;
      $display("FAIL reopen_pulse: got %0d pulses first at %0d expected 1 at 75", pulses, first_pulse);
    end
  endtask

  task automatic test_hold_extend();
    reset_a();
    boton_a = 1'b1;
    for (int cyc = 1; cyc <= 43; cyc++) begin
      step();
      if (cyc == 1) boton_a = 1'b0;
      if (cyc == 23) boton_a = 1'b1;
      if (cyc == 31) boton_a = 1'b0;
      if (cyc == 29 || cyc == 38) begin
        checks++;
        if ({led_a, door_open_a} !== 11'b00000000001) begin
          errors++;
          $display("FAIL hold_extend@%0d: got %b expected 00000000001", cyc, {led_a, door_open_a});
        end
      end
      if (cyc == 39) begin
        checks++;
        if ({led_a, door_open_a, busy_a} !== 12'b000000000001) begin
          errors++;
          $display("FAIL hold_extend@39: got %b expected 000000000001", {led_a, door_open_a, busy_a});
        end
      end
      if (cyc == 43) begin
        checks++;
        if (led_a !== 10'b1000000001) begin
          errors++;
          $display("FAIL hold_extend@43: got %b expected 1000000001", led_a);
        end
      end
    end
  endtask

  task automatic test_boton_tick_coincident();
    int pulses;
    int first_pulse;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    boton_b = 1'b1;
    step();
    boton_b = 1'b0;
    for (int cyc = 2; cyc <= 11; cyc++) begin
      step();
      if (cyc == 8) begin
        checks++;
        if ({led_b, door_open_b, busy_b} !== 12'b000000000001) begin
          errors++;
          $display("FAIL coincident@8: got %b expected 000000000001", {led_b, door_open_b, busy_b});
        end
      end
    end
    checks++;
    if (led_b !== 10'b1110000111) begin
      errors++;
      $display("FAIL coincident@11: got %b expected 1110000111", led_b);
    end
    boton_b = 1'b1;
    step();
    checks++;
    if ({led_b, door_open_b, busy_b} !== {10'b1110000111, 2'b01}) begin
      errors++;
      $display("FAIL coincident@12: got %b expected %b", {led_b, door_open_b, busy_b}, {10'b1110000111, 2'b01});
    end
    step();
    checks++;
    if (led_b !== 10'b1100000011) begin
      errors++;
      $display("FAIL coincident@13: got %b expected 1100000011", led_b);
    end
    pulses = 0;
    for (int cyc = 14; cyc <= 25; cyc++) begin
      step();
      if (person_in_b === 1'b1) pulses++;
    end
    checks++;
    if ({door_open_b, pulses != 0} !== 2'b10) begin
      errors++;
      $display("FAIL coincident_held: door_open %b pulses %0d expected 1 and 0", door_open_b, pulses);
    end
    boton_b = 1'b0;
    first_pulse = 0;
    for (int cyc = 26; cyc <= 40; cyc++) begin
      step();
      if (person_in_b === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = cyc;
      end
    end
    checks++;
    if (pulses !== 1 || first_pulse !== 32) begin
      errors++;
      $display("FAIL coincident_release: got %0d pulses first at %0d expected 1 at 32", pulses, first_pulse);
    end
  endtask

  task automatic test_reset_mid_open();
    int bad;
    reset_a();
    boton_a = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step();
      boton_a = 1'b0;
    end
    checks++;
    if (led_a !== 10'b1110000111) begin
      errors++;
      $display("FAIL mid_open_pre: got %b expected 1110000111", led_a);
    end
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    checks++;
    if ({led_a, door_open_a, busy_a, person_in_a} !== {10'b1111111111, 3'b000}) begin
      errors++;
      $display("FAIL mid_open_reset: got %b expected %b", {led_a, door_open_a, busy_a, person_in_a}, {10'b1111111111, 3'b000});
    end
    bad = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      step();
      if (busy_a !== 1'b0 || person_in_a !== 1'b0 || led_a !== 10'b1111111111) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL mid_open_idle: got %0d non-idle cycles expected 0", bad);
    end
  endtask

  task automatic test_latency();
    int cyc;
    int asym;
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    boton_c = 1'b1;
    step();
    boton_c = 1'b0;
    cyc = 1;
    asym = 0;
    while (person_in_c !== 1'b1 && cyc < 200) begin
      if (led_c[0] !== led_c[1]) asym++;
      step();
      cyc++;
    end
    checks++;
    if (cyc !== 13) begin
      errors++;
      $display("FAIL latency_w2: got %0d cycles expected 13", cyc);
    end
    checks++;
    if (asym !== 0) begin
      errors++;
      $display("FAIL symmetry_w2: got %0d asymmetric cycles expected 0", asym);
    end
    step();
    checks++;
    if ({busy_c, person_in_c, led_c} !== 4'b0011) begin
      errors++;
      $display("FAIL after_w2: got %b expected 0011", {busy_c, person_in_c, led_c});
    end

    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    boton_d = 1'b1;
    step();
    boton_d = 1'b0;
    cyc = 1;
    asym = 0;
    while (person_in_d !== 1'b1 && cyc < 400) begin
      for (int i = 0; i < 8; i++) begin
        if (led_d[i] !== led_d[15-i]) asym++;
      end
      if (cyc == 33 && led_d !== 16'b0000000000000000) asym++;
      step();
      cyc++;
    end
    checks++;
    if (cyc !== 69) begin
      errors++;
      $display("FAIL latency_w16: got %0d cycles expected 69", cyc);
    end
    checks++;
    if (asym !== 0) begin
      errors++;
      $display("FAIL symmetry_w16: got %0d bad samples expected 0", asym);
    end
  endtask

  initial begin
    test_reset();
    test_open_close();
    test_reopen();
    test_hold_extend();
    test_boton_tick_coincident();
    test_reset_mid_open();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
